// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: access width encoding, captured request, FSM states.
package mem_access_unit_pkg;
  localparam int MAU_ADDR_W    = 32;
  localparam int MAU_DATA_W    = 32;
  localparam int MAU_NUM_LANES = MAU_DATA_W / 8;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_BYTE = 2'b01,
    W_HALF = 2'b10,
    W_WORD = 2'b11
  } mem_width_e;

  typedef struct packed {
    logic                  is_store;
    logic [MAU_ADDR_W-1:0] addr;
    logic [MAU_DATA_W-1:0] wdata;
    mem_width_e            width;
    logic                  is_unsigned;
  } mem_req_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} mau_state_e;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering for stores, load extract/extend, and misalignment check.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]            i_addr_lo,
  input  logic [1:0]            i_width,
  input  logic                  i_unsigned,
  input  logic [MAU_DATA_W-1:0] i_wdata,
  input  logic [MAU_DATA_W-1:0] i_rdata,
  output logic [MAU_NUM_LANES-1:0] o_be,
  output logic [MAU_DATA_W-1:0] o_wdata,
  output logic [MAU_DATA_W-1:0] o_rdata,
  output logic                  o_misaligned
);
  mem_width_e  w_width;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_width = mem_width_e'(i_width);

  for (genvar l = 0; l < MAU_NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LANE = 2'(l);
    assign o_be[l] = (w_width == W_WORD)
                   | ((w_width == W_HALF) & (i_addr_lo[1] == LANE[1]))
                   | ((w_width == W_BYTE) & (i_addr_lo == LANE));
    // Sub-word stores replicate the datum so every enabled lane sees it.
    assign o_wdata[8*l +: 8] = (w_width == W_BYTE) ? i_wdata[7:0] :
                               (w_width == W_HALF) ? i_wdata[8*(l%2) +: 8] :
                                                     i_wdata[8*l +: 8];
  end

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_rdata = '0;
    case (w_width)
      W_BYTE:  o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      W_HALF:  o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      W_WORD:  o_rdata = i_rdata;
      default: o_rdata = '0;
    endcase
  end

  assign o_misaligned = ((w_width == W_HALF) & i_addr_lo[0])
                      | ((w_width == W_WORD) & (|i_addr_lo));
endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: single-outstanding data bus master with flush kill and aligned load return.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = MAU_ADDR_W,
  parameter int DATA_W = MAU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_is_store,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_width,
  input  logic              i_req_unsigned,
  input  logic              i_flush,
  output logic              o_dmem_req_valid,
  input  logic              i_dmem_req_ready,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic [3:0]        o_dmem_be,
  input  logic              i_dmem_rsp_valid,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_misaligned
);
  mau_state_e        r_state, w_next;
  mem_req_t          r_req;
  logic              r_kill, r_misal;
  logic [DATA_W-1:0] r_data;

  logic              w_accept, w_kill, w_resp_valid, w_misal;
  logic [1:0]        w_al_addr;
  mem_width_e        w_al_width;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_ext;

  // Aligner looks at the incoming op while idle (misalign check) and the captured op otherwise.
  assign w_al_addr  = (r_state == S_IDLE) ? i_req_addr[1:0] : r_req.addr[1:0];
  assign w_al_width = (r_state == S_IDLE) ? mem_width_e'(i_req_width) : r_req.width;

  mem_access_unit_lane_align u_align (
    .i_addr_lo    (w_al_addr),
    .i_width      (w_al_width),
    .i_unsigned   (r_req.is_unsigned),
    .i_wdata      (r_req.wdata),
    .i_rdata      (i_dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_ext),
    .o_misaligned (w_misal)
  );

  assign w_accept = (r_state == S_IDLE) & i_req_valid & ~i_flush;
  assign w_kill   = r_kill | i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    o_req_ready      = 1'b0;
    o_dmem_req_valid = 1'b0;
    w_resp_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept)
          w_next = (w_al_width == W_NONE || w_misal) ? S_RESP : S_REQ;
      end
      S_REQ: begin
        o_dmem_req_valid = 1'b1;
        if (i_dmem_req_ready)
          w_next = !r_req.is_store ? S_WAIT : (w_kill ? S_IDLE : S_RESP);
      end
      S_WAIT: begin
        if (i_dmem_rsp_valid) w_next = w_kill ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        w_resp_valid = ~i_flush;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_kill  <= 1'b0;
      r_misal <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_req   <= '{is_store: i_req_is_store, addr: i_req_addr, wdata: i_req_wdata,
                   width: mem_width_e'(i_req_width), is_unsigned: i_req_unsigned};
      r_kill  <= 1'b0;
      r_misal <= w_misal;
      r_data  <= '0;
    end else begin
      // A flushed op still finishes its bus transaction; the kill flag drops its result.
      if (i_flush && (r_state == S_REQ || r_state == S_WAIT)) r_kill <= 1'b1;
      if (r_state == S_WAIT && i_dmem_rsp_valid && !w_kill) r_data <= w_ext;
    end
  end

  assign o_dmem_we         = o_dmem_req_valid & r_req.is_store;
  assign o_dmem_addr       = o_dmem_req_valid ? {r_req.addr[ADDR_W-1:2], 2'b00} : '0;
  assign o_dmem_wdata      = o_dmem_req_valid ? w_wdata : '0;
  assign o_dmem_be         = o_dmem_req_valid ? w_be : '0;
  assign o_resp_valid      = w_resp_valid;
  assign o_resp_data       = w_resp_valid ? r_data : '0;
  assign o_resp_misaligned = w_resp_valid & r_misal;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores with stall, misalignment, flush, reset, streams.
module tb_mem_access_unit;
  localparam logic [1:0] NONE = 2'b00, BYTE = 2'b01, HALF = 2'b10, WORD = 2'b11;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req_valid = 0, i_req_is_store = 0, i_req_unsigned = 0, i_flush = 0;
  logic [31:0] i_req_addr = 0, i_req_wdata = 0, i_dmem_rdata = 0;
  logic [1:0] i_req_width = 0;
  logic i_dmem_req_ready = 0, i_dmem_rsp_valid = 0;
  logic o_req_ready, o_dmem_req_valid, o_dmem_we, o_resp_valid, o_resp_misaligned;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_resp_data;
  logic [3:0] o_dmem_be;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_is_store(i_req_is_store), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_width(i_req_width), .i_req_unsigned(i_req_unsigned), .i_flush(i_flush),
    .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_rsp_valid(i_dmem_rsp_valid), .i_dmem_rdata(i_dmem_rdata),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_misaligned(o_resp_misaligned)
  );

  task automatic drive_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] w, input logic u);
    i_req_valid = 1; i_req_is_store = st; i_req_addr = a; i_req_wdata = wd;
    i_req_width = w; i_req_unsigned = u;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_req_ready, o_dmem_req_valid, o_dmem_we, o_resp_valid, o_resp_misaligned} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=10000",
        {o_req_ready, o_dmem_req_valid, o_dmem_we, o_resp_valid, o_resp_misaligned});
    end
    n_tests++;
    if ({o_dmem_addr, o_dmem_wdata, o_dmem_be, o_resp_data} !== 100'h0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {o_dmem_addr, o_dmem_wdata, o_dmem_be, o_resp_data});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  // addr, width, unsigned, bus rdata, expected be, expected result
  localparam logic [31:0] LA [6] = '{32'h103, 32'h202, 32'h200, 32'h101, 32'h300, 32'h302};
  localparam logic [1:0]  LW [6] = '{BYTE, HALF, HALF, BYTE, WORD, BYTE};
  localparam logic        LU [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] LR [6] = '{32'h80AA_BBCC, 32'h9234_5678, 32'h9234_8678,
                                     32'h1122_F344, 32'hCAFE_F00D, 32'h007F_0000};
  localparam logic [3:0]  LB [6] = '{4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111, 4'b0100};
  localparam logic [31:0] LD [6] = '{32'hFFFF_FF80, 32'h0000_9234, 32'hFFFF_8678,
                                     32'h0000_00F3, 32'hCAFE_F00D, 32'h0000_007F};

  task automatic test_loads;
    for (int i = 0; i < 6; i++) begin
      drive_req(0, LA[i], 32'hFFFF_FFFF, LW[i], LU[i]);
      i_dmem_req_ready = 1;
      @(negedge clk); i_req_valid = 0;
      n_tests++;
      if ({o_dmem_req_valid, o_dmem_we, o_dmem_addr, o_dmem_be} !== {2'b10, LA[i] & 32'hFFFF_FFFC, LB[i]}) begin
        n_fail++; $display("FAIL load%0d_bus got=%b/%b/%h/%b exp=1/0/%h/%b", i, o_dmem_req_valid,
          o_dmem_we, o_dmem_addr, o_dmem_be, LA[i] & 32'hFFFF_FFFC, LB[i]);
      end
      @(negedge clk);
      n_tests++;
      if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL load%0d_early got=%b exp=0", i, o_resp_valid); end
      i_dmem_rsp_valid = 1; i_dmem_rdata = LR[i];
      @(negedge clk); i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
      n_tests++;
      if ({o_resp_valid, o_resp_misaligned, o_resp_data} !== {2'b10, LD[i]}) begin
        n_fail++; $display("FAIL load%0d_resp got=%b/%b/%h exp=1/0/%h", i, o_resp_valid,
          o_resp_misaligned, o_resp_data, LD[i]);
      end
      @(negedge clk);
      n_tests++;
      if ({o_resp_valid, o_req_ready} !== 2'b01) begin
        n_fail++; $display("FAIL load%0d_idle got=%b exp=01", i, {o_resp_valid, o_req_ready});
      end
    end
  endtask

  localparam logic [31:0] SA [3] = '{32'h101, 32'h202, 32'h300};
  localparam logic [1:0]  SW [3] = '{BYTE, HALF, WORD};
  localparam logic [31:0] SD [3] = '{32'hFFFF_FF12, 32'h5555_ABCD, 32'hCAFE_BABE};
  localparam int          SS [3] = '{3, 0, 1};
  localparam logic [3:0]  SB [3] = '{4'b0010, 4'b1100, 4'b1111};
  localparam logic [31:0] SE [3] = '{32'h1212_1212, 32'hABCD_ABCD, 32'hCAFE_BABE};

  task automatic test_stores;
    for (int i = 0; i < 3; i++) begin
      drive_req(1, SA[i], SD[i], SW[i], 0);
      i_dmem_req_ready = 0;
      @(negedge clk); i_req_valid = 0;
      for (int s = 0; s <= SS[i]; s++) begin
        n_tests++;
        if ({o_dmem_req_valid, o_dmem_we, o_resp_valid, o_dmem_addr, o_dmem_be, o_dmem_wdata}
            !== {3'b110, SA[i] & 32'hFFFF_FFFC, SB[i], SE[i]}) begin
          n_fail++; $display("FAIL store%0d_bus_c%0d got=%b%b%b/%h/%b/%h exp=110/%h/%b/%h", i, s,
            o_dmem_req_valid, o_dmem_we, o_resp_valid, o_dmem_addr, o_dmem_be, o_dmem_wdata,
            SA[i] & 32'hFFFF_FFFC, SB[i], SE[i]);
        end
        if (s == SS[i]) i_dmem_req_ready = 1;
        @(negedge clk);
      end
      i_dmem_req_ready = 0;
      n_tests++;
      if ({o_resp_valid, o_resp_misaligned, o_resp_data, o_dmem_req_valid} !== {2'b10, 32'h0, 1'b0}) begin
        n_fail++; $display("FAIL store%0d_resp got=%b/%b/%h exp=1/0/0", i, o_resp_valid,
          o_resp_misaligned, o_resp_data);
      end
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] MA [4] = '{32'h102, 32'h201, 32'h203, 32'h102};
  localparam logic [1:0]  MW [4] = '{WORD, HALF, HALF, NONE};
  localparam logic        MS [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        MM [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  task automatic test_misaligned;
    for (int i = 0; i < 4; i++) begin
      drive_req(MS[i], MA[i], 32'h1234_5678, MW[i], 0);
      i_dmem_req_ready = 1;
      @(negedge clk); i_req_valid = 0;
      n_tests++;
      if ({o_resp_valid, o_resp_misaligned, o_dmem_req_valid, o_resp_data} !== {1'b1, MM[i], 1'b0, 32'h0}) begin
        n_fail++; $display("FAIL mis%0d_resp got=%b/%b/%b/%h exp=1/%b/0/0", i, o_resp_valid,
          o_resp_misaligned, o_dmem_req_valid, o_resp_data, MM[i]);
      end
      @(negedge clk);
      n_tests++;
      if ({o_resp_valid, o_req_ready, o_dmem_req_valid} !== 3'b010) begin
        n_fail++; $display("FAIL mis%0d_idle got=%b exp=010", i, {o_resp_valid, o_req_ready, o_dmem_req_valid});
      end
    end
  endtask

  task automatic test_flush;
    // flush beats reqValid in IDLE
    drive_req(0, 32'h400, 0, WORD, 0); i_flush = 1; i_dmem_req_ready = 1;
    @(negedge clk); i_req_valid = 0; i_flush = 0;
    n_tests++;
    if ({o_dmem_req_valid, o_resp_valid, o_req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL flush_idle got=%b exp=001", {o_dmem_req_valid, o_resp_valid, o_req_ready});
    end
    // flush in WAIT drops the response
    drive_req(0, 32'h400, 0, WORD, 0);
    @(negedge clk); i_req_valid = 0;
    @(negedge clk); i_flush = 1;
    @(negedge clk); i_flush = 0; i_dmem_rsp_valid = 1; i_dmem_rdata = 32'hDEAD_BEEF;
    n_tests++;
    if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_a got=%b exp=0", o_resp_valid); end
    @(negedge clk); i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
    n_tests++;
    if ({o_resp_valid, o_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_wait_b got=%b exp=01", {o_resp_valid, o_req_ready});
    end
    drive_req(0, 32'h404, 0, WORD, 0);
    @(negedge clk); i_req_valid = 0;
    @(negedge clk); i_dmem_rsp_valid = 1; i_dmem_rdata = 32'h0123_4567;
    @(negedge clk); i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
    n_tests++;
    if ({o_resp_valid, o_resp_data} !== {1'b1, 32'h0123_4567}) begin
      n_fail++; $display("FAIL flush_next got=%b/%h exp=1/01234567", o_resp_valid, o_resp_data);
    end
    @(negedge clk);
    // flush in REQ: store still goes out, no response
    drive_req(1, 32'h500, 32'h1122_3344, WORD, 0); i_dmem_req_ready = 0;
    @(negedge clk); i_req_valid = 0; i_flush = 1;
    @(negedge clk); i_flush = 0;
    n_tests++;
    if ({o_dmem_req_valid, o_dmem_we, o_dmem_wdata} !== {2'b11, 32'h1122_3344}) begin
      n_fail++; $display("FAIL flush_req_hold got=%b%b/%h exp=11/11223344", o_dmem_req_valid, o_dmem_we, o_dmem_wdata);
    end
    i_dmem_req_ready = 1;
    @(negedge clk); i_dmem_req_ready = 0;
    n_tests++;
    if ({o_resp_valid, o_req_ready, o_dmem_req_valid} !== 3'b010) begin
      n_fail++; $display("FAIL flush_req_kill got=%b exp=010", {o_resp_valid, o_req_ready, o_dmem_req_valid});
    end
    // flush in RESP masks respValid
    drive_req(0, 32'h102, 0, WORD, 0);
    @(negedge clk); i_req_valid = 0; i_flush = 1;
    #1;
    n_tests++;
    if ({o_resp_valid, o_resp_misaligned} !== 2'b00) begin
      n_fail++; $display("FAIL flush_resp got=%b exp=00", {o_resp_valid, o_resp_misaligned});
    end
    @(negedge clk); i_flush = 0;
    n_tests++;
    if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resp_idle got=%b exp=1", o_req_ready); end
  endtask

  task automatic test_reset_mid;
    drive_req(0, 32'h500, 0, WORD, 0); i_dmem_req_ready = 1;
    @(negedge clk); i_req_valid = 0;
    @(negedge clk); rst_n = 0;
    #1;
    n_tests++;
    if ({o_req_ready, o_dmem_req_valid, o_resp_valid, o_dmem_be, o_dmem_addr} !== {3'b100, 4'h0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid got=%b/%b/%b/%b/%h exp=1/0/0/0000/0", o_req_ready,
        o_dmem_req_valid, o_resp_valid, o_dmem_be, o_dmem_addr);
    end
    @(negedge clk); rst_n = 1; i_dmem_rsp_valid = 1; i_dmem_rdata = 32'h5A5A_5A5A;
    @(negedge clk); i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
    n_tests++;
    if ({o_resp_valid, o_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_stray_rsp got=%b exp=01", {o_resp_valid, o_req_ready});
    end
  endtask

  localparam logic        BS [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] BA [6] = '{32'h600, 32'h604, 32'h607, 32'h605, 32'h606, 32'h60A};
  localparam logic [1:0]  BW [6] = '{WORD, WORD, BYTE, BYTE, HALF, HALF};
  localparam logic        BU [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] BD [6] = '{32'h0, 32'h2468_ACE0, 32'h0, 32'h0, 32'h0000_BEEF, 32'h0};
  localparam logic [31:0] BR [6] = '{32'h1357_9BDF, 32'h0, 32'hF000_0000, 32'h0000_A500, 32'h0, 32'h7FFF_0000};
  localparam logic [3:0]  BB [6] = '{4'b1111, 4'b1111, 4'b1000, 4'b0010, 4'b1100, 4'b1100};
  localparam logic [31:0] BWD[6] = '{32'h0, 32'h2468_ACE0, 32'h0, 32'h0, 32'hBEEF_BEEF, 32'h0};
  localparam logic [31:0] BE [6] = '{32'h1357_9BDF, 32'h0, 32'hFFFF_FFF0, 32'h0000_00A5, 32'h0, 32'h0000_7FFF};

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 6; i++) begin
      drive_req(BS[i], BA[i], BD[i], BW[i], BU[i]); i_dmem_req_ready = 0;
      @(negedge clk); i_req_valid = 0;
      lat = $urandom_range(0, 3);
      for (int s = 0; s <= lat; s++) begin
        n_tests++;
        if ({o_dmem_req_valid, o_dmem_we, o_dmem_addr, o_dmem_be} !== {1'b1, BS[i], BA[i] & 32'hFFFF_FFFC, BB[i]}) begin
          n_fail++; $display("FAIL b2b%0d_bus got=%b%b/%h/%b exp=1%b/%h/%b", i, o_dmem_req_valid,
            o_dmem_we, o_dmem_addr, o_dmem_be, BS[i], BA[i] & 32'hFFFF_FFFC, BB[i]);
        end
        if (BS[i]) begin
          n_tests++;
          if (o_dmem_wdata !== BWD[i]) begin
            n_fail++; $display("FAIL b2b%0d_wdata got=%h exp=%h", i, o_dmem_wdata, BWD[i]);
          end
        end
        if (s == lat) i_dmem_req_ready = 1;
        @(negedge clk);
      end
      i_dmem_req_ready = 0;
      if (!BS[i]) begin
        lat = $urandom_range(0, 2);
        for (int s = 0; s <= lat; s++) begin
          n_tests++;
          if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_early got=%b exp=0", i, o_resp_valid); end
          if (s == lat) begin i_dmem_rsp_valid = 1; i_dmem_rdata = BR[i]; end
          @(negedge clk);
        end
        i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
      end
      n_tests++;
      if ({o_resp_valid, o_resp_misaligned, o_resp_data} !== {2'b10, BE[i]}) begin
        n_fail++; $display("FAIL b2b%0d_resp got=%b/%b/%h exp=1/0/%h", i, o_resp_valid,
          o_resp_misaligned, o_resp_data, BE[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
